// File: rtl/mem_pkg.sv
// Shared definitions for the instruction/data RAM port arbiter:
// requester command codes, arbiter FSM states and default widths.
package mem_pkg;

  localparam int unsigned AW_DEFAULT = 9;
  localparam int unsigned DW_DEFAULT = 16;

  localparam logic [1:0] MNONE    = 2'b00;
  localparam logic [1:0] MREAD    = 2'b01;
  localparam logic [1:0] MWRITE   = 2'b11;
  localparam logic [1:0] MILLEGAL = 2'b10;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StDone   = 2'b10
  } arb_state_e;

  function automatic logic cmd_valid(input logic [1:0] cmd);
    return (cmd == MREAD) || (cmd == MWRITE);
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin picker: on a tie the requester that did
// not win last time is chosen.
module arb_rr2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |valid;
    case (valid)
      2'b11:   grant_id = ~last;
      2'b10:   grant_id = 1'b1;
      default: grant_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port RAM between the CPU (requester 0) and the loader
// (requester 1); one access per grant, finished by a one-cycle ack.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned AW = AW_DEFAULT,
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    cmd0,
  input  logic [1:0]    cmd1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_write,
  input  logic [DW-1:0] ram_dout
);

  arb_state_e    state_q, state_d;
  logic          last_q, last_d;
  logic          win_id_q, win_id_d;
  logic          win_wr_q, win_wr_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic          ram_write_q, ram_write_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic [1:0]    valid;
  logic          grant_valid;
  logic          grant_id;

  assign valid = {cmd_valid(cmd1), cmd_valid(cmd0)};

  arb_rr2 u_arb_rr2 (
    .valid       (valid),
    .last        (last_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    win_id_d    = win_id_q;
    win_wr_d    = win_wr_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    ram_write_d = 1'b0;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;

    case (state_q)
      StIdle: begin
        err_d = (cmd0 == MILLEGAL) || (cmd1 == MILLEGAL);
        if (grant_valid) begin
          state_d     = StAccess;
          last_d      = grant_id;
          win_id_d    = grant_id;
          win_wr_d    = grant_id ? (cmd1 == MWRITE) : (cmd0 == MWRITE);
          ram_addr_d  = grant_id ? addr1 : addr0;
          ram_din_d   = grant_id ? wdata1 : wdata0;
          ram_write_d = win_wr_d;
        end
      end
      StAccess: begin
        state_d = StDone;
        ack0_d  = ~win_id_q;
        ack1_d  = win_id_q;
      end
      StDone: begin
        state_d = StIdle;
        if (!win_wr_q) rdata_d = ram_dout;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      win_id_q    <= 1'b0;
      win_wr_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      ram_write_q <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      win_id_q    <= win_id_d;
      win_wr_q    <= win_wr_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      ram_write_q <= ram_write_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err       = err_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_write = ram_write_q;

  // ram_dout is already a RAM register; passing it through during a read ack
  // lets rdata line up with the ack, and rdata_q holds it afterwards.
  assign rdata = (state_q == StDone && !win_wr_q) ? ram_dout : rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model
// of grants, ack timing and RAM contents.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    cmd0, cmd1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, err, ram_write;
  logic [DW-1:0] rdata, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;

  int vec_count  = 0;
  int miss_count = 0;

  // Reference model state
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  logic          last_exp;
  logic [DW-1:0] rdata_exp;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd0      (cmd0),
    .cmd1      (cmd1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata     (rdata),
    .err       (err),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_write (ram_write),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int unsigned i);
    return 16'h1234 ^ DW'((i ^ 5) * 257);
  endfunction

  // Synchronous-read RAM, contents seeded on the first clock edge.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic          ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int unsigned i = 0; i < (1 << AW); i++) ram[i] <= init_val(i);
      ram_ready <= 1'b1;
    end else if (ram_write) begin
      ram[ram_addr] <= ram_din;
    end
    ram_dout <= ram[ram_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miss_count++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Presents one pair of commands in an IDLE cycle and checks the whole
  // resulting transaction. Returns the predicted winner (-1 for none).
  task automatic do_slot(input logic [1:0] c0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic [1:0] c1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         output int winner);
    logic          v0, v1, wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    cmd0 = c0; addr0 = a0; wdata0 = d0;
    cmd1 = c1; addr1 = a1; wdata1 = d1;
    v0 = (c0 == MREAD) || (c0 == MWRITE);
    v1 = (c1 == MREAD) || (c1 == MWRITE);
    if (v0 && v1)  winner = last_exp ? 0 : 1;
    else if (v0)   winner = 0;
    else if (v1)   winner = 1;
    else           winner = -1;
    @(negedge clk);
    check_eq("err", 32'(err), 32'((c0 == MILLEGAL) || (c1 == MILLEGAL)));
    check_eq("ack0_early", 32'(ack0), 32'd0);
    check_eq("ack1_early", 32'(ack1), 32'd0);
    if (winner < 0) begin
      check_eq("ram_write_idle", 32'(ram_write), 32'd0);
      return;
    end
    last_exp = (winner == 1);
    wr = (winner == 1) ? (c1 == MWRITE) : (c0 == MWRITE);
    a  = (winner == 1) ? a1 : a0;
    d  = (winner == 1) ? d1 : d0;
    check_eq("ram_addr", 32'(ram_addr), 32'(a));
    check_eq("ram_write", 32'(ram_write), 32'(wr));
    check_eq("ram_din", 32'(ram_din), 32'(d));
    @(negedge clk);
    check_eq("ack0", 32'(ack0), 32'(winner == 0));
    check_eq("ack1", 32'(ack1), 32'(winner == 1));
    check_eq("ram_write_done", 32'(ram_write), 32'd0);
    check_eq("err_done", 32'(err), 32'd0);
    if (wr) shadow[a] = d;
    else    rdata_exp = shadow[a];
    check_eq("rdata", 32'(rdata), 32'(rdata_exp));
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ack0"}, 32'(ack0), 32'd0);
    check_eq({tag, "_ack1"}, 32'(ack1), 32'd0);
    check_eq({tag, "_err"}, 32'(err), 32'd0);
    check_eq({tag, "_ram_write"}, 32'(ram_write), 32'd0);
    check_eq({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check_eq({tag, "_ram_din"}, 32'(ram_din), 32'd0);
    check_eq({tag, "_rdata"}, 32'(rdata), 32'd0);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, (1 << AW) - 1));
    return AW'($urandom_range(0, 15));
  endfunction

  initial begin
    int            w;
    logic          p0, p1;
    logic [1:0]    rc0, rc1;
    logic [AW-1:0] ra0, ra1;
    logic [DW-1:0] rd0, rd1;

    for (int unsigned i = 0; i < (1 << AW); i++) shadow[i] = init_val(i);
    last_exp  = 1'b1;
    rdata_exp = '0;
    cmd0 = MNONE; cmd1 = MNONE;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    #2;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Single read of the preset word, write from the loader, read it back
    do_slot(MREAD, AW'(9'h05), '0, MNONE, '0, '0, w);
    check_eq("rd05_data", 32'(rdata_exp), 32'h1234);
    do_slot(MNONE, '0, '0, MWRITE, AW'(9'h1F), 16'hBEEF, w);
    do_slot(MREAD, AW'(9'h1F), '0, MNONE, '0, '0, w);
    check_eq("rd1f_data", 32'(rdata_exp), 32'hBEEF);

    // Reset in the middle of a read aborts it
    cmd0 = MREAD; addr0 = AW'(9'h05); cmd1 = MNONE;
    @(negedge clk);
    reset = 1'b1;
    cmd0  = MNONE;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    reset     = 1'b0;
    last_exp  = 1'b1;
    rdata_exp = '0;
    repeat (3) begin
      @(negedge clk);
      check_eq("post_reset_ack0", 32'(ack0), 32'd0);
      check_eq("post_reset_ack1", 32'(ack1), 32'd0);
    end

    // First tie after reset goes to requester 0, then requester 1
    do_slot(MREAD, AW'(9'h03), '0, MREAD, AW'(9'h04), '0, w);
    check_eq("tie_first", 32'(w), 32'd0);
    do_slot(MNONE, '0, '0, MREAD, AW'(9'h04), '0, w);
    check_eq("tie_second", 32'(w), 32'd1);

    // Illegal command from requester 0 does not block requester 1
    do_slot(MILLEGAL, AW'(9'h02), '0, MREAD, AW'(9'h07), '0, w);
    check_eq("illegal_winner", 32'(w), 32'd1);

    // Sustained contention: both re-request right after each ack
    rc0 = MREAD; ra0 = rand_addr(); rd0 = DW'($urandom);
    rc1 = MWRITE; ra1 = rand_addr(); rd1 = DW'($urandom);
    for (int t = 0; t < 8; t++) begin
      do_slot(rc0, ra0, rd0, rc1, ra1, rd1, w);
      check_eq("contention_order", 32'(w), 32'(t % 2));
      if (w == 0) begin
        rc0 = $urandom_range(0, 1) ? MREAD : MWRITE; ra0 = rand_addr(); rd0 = DW'($urandom);
      end else begin
        rc1 = $urandom_range(0, 1) ? MREAD : MWRITE; ra1 = rand_addr(); rd1 = DW'($urandom);
      end
    end

    // Random traffic: losers hold their request until acked
    p0 = 1'b0; p1 = 1'b0;
    rc0 = MNONE; rc1 = MNONE;
    for (int s = 0; s < 300; s++) begin
      if (!p0) begin
        case ($urandom_range(0, 9))
          0, 1, 2: rc0 = MNONE;
          3:       rc0 = MILLEGAL;
          4, 5, 6: rc0 = MREAD;
          default: rc0 = MWRITE;
        endcase
        ra0 = rand_addr(); rd0 = DW'($urandom);
        p0 = (rc0 == MREAD) || (rc0 == MWRITE);
      end
      if (!p1) begin
        case ($urandom_range(0, 9))
          0, 1, 2: rc1 = MNONE;
          3:       rc1 = MILLEGAL;
          4, 5, 6: rc1 = MREAD;
          default: rc1 = MWRITE;
        endcase
        ra1 = rand_addr(); rd1 = DW'($urandom);
        p1 = (rc1 == MREAD) || (rc1 == MWRITE);
      end
      do_slot(rc0, ra0, rd0, rc1, ra1, rd1, w);
      if (w == 0) p0 = 1'b0;
      if (w == 1) p1 = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
